// File: rtl/serdes_pkg.sv
// ---------------------------------------------------------------------------
// serdes_pkg
// Shared definitions for the serializer/deserializer family.
//   serdes_state_t        : two-state control FSM encoding (IDLE, SHIFT)
//   SERDES_DEFAULT_WIDTH  : default word width used by the serializer
//   SERDES_LSB_FIRST/MSB  : bit-order encodings for the MSB_FIRST parameter
// ---------------------------------------------------------------------------
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serdes_state_t;

    localparam int SERDES_DEFAULT_WIDTH = 4;

    localparam bit SERDES_LSB_FIRST = 1'b0;
    localparam bit SERDES_MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out stage. Accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per clock on out_bit, MSB first by default.
// Back-to-back words stream with no idle bubble: the next word is accepted
// in the last-bit cycle of the current one.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    word to serialize, sampled only on acceptance
//   in_valid   upstream has a word
//   in_ready   block can accept a word this cycle (combinational)
//   out_bit    serial data (registered)
//   out_frame  high while out_bit carries a data bit (registered)
//   out_last   high while out_bit carries the final bit of a word (registered)
// ---------------------------------------------------------------------------
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH      = SERDES_DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = SERDES_MSB_FIRST,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_frame,
    output logic             out_last
);

    localparam int            CW          = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRELAST_CNT = CW'(WIDTH - 2);

    serdes_state_t    state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;

    logic             accept;
    logic             first_bit;
    logic [WIDTH-1:0] load_rest;
    logic             next_bit;
    logic [WIDTH-1:0] shifted;

    // Ready in IDLE, or in the last-bit cycle of a word so the next word can
    // follow without a bubble. Deliberately independent of in_valid.
    assign in_ready = (state == IDLE) || (cnt == LAST_CNT);
    assign accept   = in_valid && in_ready;

    // The first bit goes straight to out_bit at acceptance, so the shift
    // register only keeps the remaining bits, already shifted once.
    assign first_bit = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign load_rest = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
    assign next_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shifted   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    // Control FSM plus datapath. Acceptance is only possible in IDLE or at
    // the last bit, so it takes priority and covers both the start of a
    // word and the zero-bubble reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            out_bit   <= IDLE_LEVEL;
            out_frame <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            cnt       <= '0;
            shreg     <= load_rest;
            out_bit   <= first_bit;
            out_frame <= 1'b1;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                SHIFT: begin
                    if (cnt != LAST_CNT) begin
                        cnt      <= cnt + CW'(1);
                        shreg    <= shifted;
                        out_bit  <= next_bit;
                        out_last <= (cnt == PRELAST_CNT);
                    end else begin
                        state     <= IDLE;
                        cnt       <= '0;
                        shreg     <= '0;
                        out_bit   <= IDLE_LEVEL;
                        out_frame <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    shreg     <= '0;
                    out_bit   <= IDLE_LEVEL;
                    out_frame <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Directed bench for piso_serializer. Three instances share clock and reset:
//   dut     : WIDTH=4, MSB first, feeding a 4-bit downstream shift register
//   dut_lsb : WIDTH=4, LSB first
//   dut_w8  : WIDTH=8, MSB first, driven with random words and gaps and
//             checked by a reconstructing scoreboard
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;

    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out_bit;
    logic       out_frame;
    logic       out_last;

    logic [3:0] lsb_data;
    logic       lsb_valid;
    logic       lsb_ready;
    logic       lsb_bit;
    logic       lsb_frame;
    logic       lsb_last;

    logic [7:0] w8_data;
    logic       w8_valid;
    logic       w8_ready;
    logic       w8_bit;
    logic       w8_frame;
    logic       w8_last;

    logic [3:0] ds;

    int         checks;
    int         errors;

    logic [7:0] sb[$];
    logic [7:0] rx_word;
    int         rx_bits;
    int         rx_count;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_frame (out_frame),
        .out_last  (out_last)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (lsb_data),
        .in_valid  (lsb_valid),
        .in_ready  (lsb_ready),
        .out_bit   (lsb_bit),
        .out_frame (lsb_frame),
        .out_last  (lsb_last)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (w8_data),
        .in_valid  (w8_valid),
        .in_ready  (w8_ready),
        .out_bit   (w8_bit),
        .out_frame (w8_frame),
        .out_last  (w8_last)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream 4-bit serial-in shift register fed by the MSB-first instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ds <= 4'h0;
        else        ds <= {ds[2:0], out_bit};
    end

    // Global time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkCycle(input string tag,
                              input logic obit, input logic oframe,
                              input logic olast, input logic oready,
                              input logic ebit, input logic eframe,
                              input logic elast, input logic eready);
        checkOutput({tag, "_bit"},   {31'd0, obit},   {31'd0, ebit});
        checkOutput({tag, "_frame"}, {31'd0, oframe}, {31'd0, eframe});
        checkOutput({tag, "_last"},  {31'd0, olast},  {31'd0, elast});
        checkOutput({tag, "_ready"}, {31'd0, oready}, {31'd0, eready});
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard receiver for the 8-bit instance, sampling on falling edges
    always @(negedge clk) begin
        if (w8_frame) begin
            rx_word = {rx_word[6:0], w8_bit};
            rx_bits++;
            if (w8_last) begin
                checkOutput("w8_len", rx_bits, 32'd8);
                if (sb.size() == 0) begin
                    checkOutput("w8_unexpected_word", {24'd0, rx_word}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("w8_word", {24'd0, rx_word}, {24'd0, sb.pop_front()});
                end
                rx_count++;
                rx_bits = 0;
            end
        end
    end

    initial begin
        logic [7:0] seq;
        logic [7:0] word;
        int         gap;
        int         budget;
        logic       accepted;

        checks    = 0;
        errors    = 0;
        rx_word   = 8'h00;
        rx_bits   = 0;
        rx_count  = 0;
        rst_n     = 1'b0;
        applyStimulus(1'b0, 4'h0);
        lsb_valid = 1'b0;
        lsb_data  = 4'h0;
        w8_valid  = 1'b0;
        w8_data   = 8'h00;

        // Reset values
        #1;
        checkCycle("reset", out_bit, out_frame, out_last, in_ready, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        checkCycle("post_reset", out_bit, out_frame, out_last, in_ready, 1'b0, 1'b0, 1'b0, 1'b1);

        // Single word 1011, data changed after acceptance must be ignored
        $display("[TB] single word");
        applyStimulus(1'b1, 4'b1011);
        tick();
        applyStimulus(1'b0, 4'b0100);
        seq = 8'b1011_0000;
        for (int i = 0; i < 4; i++) begin
            checkCycle($sformatf("single%0d", i), out_bit, out_frame, out_last, in_ready,
                       seq[7-i], 1'b1, (i == 3), (i == 3));
            tick();
        end
        checkCycle("single_idle", out_bit, out_frame, out_last, in_ready, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("single_ds", {28'd0, ds}, 32'hB);

        // Back-to-back A then 5 with valid held high
        $display("[TB] back-to-back");
        applyStimulus(1'b1, 4'hA);
        tick();
        applyStimulus(1'b1, 4'h5);
        seq = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            checkCycle($sformatf("b2b%0d", i), out_bit, out_frame, out_last, in_ready,
                       seq[7-i], 1'b1, (i == 3 || i == 7), (i == 3 || i == 7));
            if (i == 7) applyStimulus(1'b0, 4'h0);
            tick();
        end
        checkCycle("b2b_idle", out_bit, out_frame, out_last, in_ready, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("b2b_ds", {28'd0, ds}, 32'h5);

        // Backpressure: C presented while word 3 is in flight
        $display("[TB] backpressure");
        applyStimulus(1'b1, 4'h3);
        tick();
        applyStimulus(1'b1, 4'hC);
        seq = 8'b0011_1100;
        for (int i = 0; i < 8; i++) begin
            checkCycle($sformatf("bp%0d", i), out_bit, out_frame, out_last, in_ready,
                       seq[7-i], 1'b1, (i == 3 || i == 7), (i == 3 || i == 7));
            if (i == 4) applyStimulus(1'b0, 4'h0);
            tick();
        end
        checkCycle("bp_idle", out_bit, out_frame, out_last, in_ready, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_ds", {28'd0, ds}, 32'hC);

        // LSB-first order: 0001 -> 1,0,0,0 then 1101 -> 1,0,1,1
        $display("[TB] lsb first");
        lsb_valid = 1'b1;
        lsb_data  = 4'b0001;
        tick();
        lsb_valid = 1'b0;
        lsb_data  = 4'b1110;
        seq = 8'b1000_1011;
        for (int i = 0; i < 4; i++) begin
            checkCycle($sformatf("lsb_a%0d", i), lsb_bit, lsb_frame, lsb_last, lsb_ready,
                       seq[7-i], 1'b1, (i == 3), (i == 3));
            tick();
        end
        checkCycle("lsb_idle", lsb_bit, lsb_frame, lsb_last, lsb_ready, 1'b0, 1'b0, 1'b0, 1'b1);
        lsb_valid = 1'b1;
        lsb_data  = 4'b1101;
        tick();
        lsb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkCycle($sformatf("lsb_b%0d", i), lsb_bit, lsb_frame, lsb_last, lsb_ready,
                       seq[3-i], 1'b1, (i == 3), (i == 3));
            tick();
        end

        // Reset asserted after two bits of 1011 aborts the word
        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 4'b1011);
        tick();
        applyStimulus(1'b0, 4'h0);
        checkCycle("abort_b0", out_bit, out_frame, out_last, in_ready, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkCycle("abort_b1", out_bit, out_frame, out_last, in_ready, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkCycle("abort_rst", out_bit, out_frame, out_last, in_ready, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        #3 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checkCycle($sformatf("abort_idle%0d", i), out_bit, out_frame, out_last, in_ready,
                       1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end

        // Width 8: random words with random gaps, reconstructed by scoreboard
        $display("[TB] width 8 random");
        for (int n = 0; n < 64; n++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                w8_valid = 1'b0;
                repeat (gap) tick();
            end
            w8_valid = 1'b1;
            w8_data  = 8'($urandom());
            word     = w8_data;
            budget   = 20;
            accepted = 1'b0;
            while (!accepted && budget > 0) begin
                accepted = w8_ready;
                tick();
                budget--;
            end
            if (!accepted) checkOutput("w8_accept_timeout", 32'd0, 32'd1);
            else           sb.push_back(word);
        end
        w8_valid = 1'b0;
        budget = 40;
        while (rx_count < 64 && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("w8_count", rx_count, 32'd64);
        checkOutput("w8_sb_empty", sb.size(), 32'd0);
        checkOutput("w8_idle_frame", {31'd0, w8_frame}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the 4-bit serial-in shift register.
- Accepts a WIDTH-bit word on a valid/ready handshake and drives it onto a single serial line, one bit per clock, MSB first by default.
- With MSB-first order, the downstream shift register holds the original word exactly WIDTH clocks after acceptance.
- Also provides frame/last qualifiers so downstream logic knows when its parallel output is a complete word.

Parameters:
- WIDTH, 4: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_LEVEL, 0: value driven on out_bit when no word is in flight.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_data  input  WIDTH  word to serialize; sampled only on handshake.
- in_valid  input  1  upstream has a word.
- in_ready  output  1  block can accept a word this cycle.
- out_bit  output  1  serial data to the downstream shift register.
- out_frame  output  1  high while out_bit carries a data bit.
- out_last  output  1  high while out_bit carries the final bit of a word.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Reset values while rst_n=0: state=IDLE, in_ready=1, out_bit=IDLE_LEVEL, out_frame=0, out_last=0, bit counter=0, shift register=0.
  - Reset asserted mid-word aborts the word immediately; no partial resume after release.
- Output timing:
  - All outputs except in_ready are registered.
  - in_ready is combinational from state and counter only; it never depends on in_valid.
- Handshake:
  - A word is accepted at a rising edge where in_valid=1 and in_ready=1.
  - in_data is captured only at acceptance; later changes to in_data are ignored.
- States:
  - IDLE: in_ready=1. On acceptance -> SHIFT, counter=0, first bit driven.
  - SHIFT: in_ready=1 only when counter==WIDTH-1, i.e. the last-bit cycle.
    - At each edge with counter<WIDTH-1: advance to the next bit, counter+1.
    - At the edge with counter==WIDTH-1: if a word is accepted, stay in SHIFT, counter=0, drive the new word's first bit (zero-bubble back-to-back). Otherwise go to IDLE, out_bit=IDLE_LEVEL, out_frame=0.
- Latency:
  - Word accepted at edge k. Bit i of the transmit order (i=0..WIDTH-1) is on out_bit in the cycle following edge k+i.
  - out_frame=1 for exactly WIDTH cycles per word.
  - out_last=1 only in the cycle of bit WIDTH-1.
  - The downstream register sampling at edges k+1..k+WIDTH holds the word after edge k+WIDTH.
- Bit order:
  - MSB_FIRST=1: shift left and emit bit WIDTH-1.
  - MSB_FIRST=0: shift right and emit bit 0.
- Counter: width $clog2(WIDTH); wraps to 0 only via the reload or IDLE paths and never exceeds WIDTH-1.
- in_valid while not ready: the word is held upstream, not dropped; no bits of the in-flight word are affected.
- out_last and in_ready are both high in the last-bit cycle of a SHIFT word; this is the only cycle in SHIFT where in_ready=1.

Decomposition:
- Shared package serdes_pkg holds:
  - state typedef (IDLE, SHIFT);
  - constant SERDES_DEFAULT_WIDTH=4, the default value of WIDTH;
  - bit-order encoding constants used by the MSB_FIRST parameter.
- No sub-module is warranted: the shift register, counter and two-state FSM fit in one module.

Test Plan:
- Reset: assert rst_n=0 mid-word (in_data=4'b1011, after 2 bits), release -> out_bit=0, out_frame=0, out_last=0, in_ready=1; no further bits emitted.
- Single word into downstream register: in_data=4'b1011, in_valid pulsed one cycle -> out_bit sequence 1,0,1,1 over 4 cycles; out_last only on the 4th; downstream out==4'b1011 after edge k+4.
- Back-to-back: in_valid held high with 4'hA then 4'h5 -> 8 consecutive frame cycles with no gap, serial 1,0,1,0,0,1,0,1; in_ready high only in cycles 4 and 8.
- Backpressure: present 4'hC during cycles 1-3 of a word -> in_ready=0 and the word is not captured; it is accepted at the last-bit cycle and its bits start the next cycle.
- LSB order (MSB_FIRST=0): in_data=4'b0001 -> serial 1,0,0,0.
- Width 8, random: 64 random words with random in_valid gaps -> a scoreboard reconstructs every word from out_bit/out_frame/out_last with no loss or duplication.
